tetris_game_ctrl: RTL and testbench
===================================

Name: tetris_game_ctrl

Overview:
Parametrised next-generation top-level game controller for the Tetris chip, sequencing NEWBOARD/GEN/MOVE/LAND/CLEAR/GAMEOVER plus a new PAUSE state. Adds capabilities the current controller lacks:
- gravity timer with level-dependent drop period
- lock-delay with bounded move resets
- req/done handshakes to the piece generator and line-clear engine
- line and level tracking

Sits between the frame-tick source, piece generator, movement datapath and clear engine.

Parameters:
DROP_BASE, 48, gravity period in frame ticks at level 0
DROP_STEP, 4, period reduction per level
DROP_MIN, 2, minimum gravity period
LOCK_TICKS, 15, frame ticks a grounded piece waits before locking
MAX_RESETS, 15, lock-timer resets allowed per piece
LINES_PER_LEVEL, 10, cleared lines per level-up (must be >= 4)
MAX_LEVEL, 15, level saturation value
LINE_W, 16, width of cleared-line counter

Ports:
clka  in  1  single system clock, all logic on rising edge
restart_n  in  1  asynchronous active-low reset
restart  in  1  synchronous new-game request
tick_en  in  1  one-cycle frame tick enable
pause  in  1  level-sensitive pause request
gen_done  in  1  piece generator done
spawn_blocked  in  1  spawn overlaps board; qualified by gen_done
grounded  in  1  active piece cannot move down
moved  in  1  successful player shift/rotate pulse
hard_drop  in  1  datapath has hard-dropped the piece
clear_done  in  1  line-clear engine done
clear_count  in  3  rows cleared (0-4); qualified by clear_done
state  out  3  current state
gen_req  out  1  request new piece
drop_tick  out  1  one-cycle gravity step pulse
lock_piece  out  1  one-cycle commit pulse
clear_req  out  1  request row scan/clear
level  out  4  current level
lines  out  LINE_W  total lines cleared, saturating

Behaviour:
- Encoding: GEN=000, MOVE=001, LAND=010, CLEAR=011, NEWBOARD=100, GAMEOVER=101, PAUSE=110; 111 illegal, recovers to NEWBOARD.
- restart_n low: state=NEWBOARD; all pulses and reqs 0; level=0; lines=0; gravity, lock and reset counters 0.
- restart high in any state: NEWBOARD next cycle; gen_req/clear_req drop that edge; highest priority.
- NEWBOARD (1 cycle): zero level, lines, level sub-counter and timers -> GEN.
- GEN: gen_req=1 registered, held until gen_done. On gen_done: gen_req drops same edge; spawn_blocked ? GAMEOVER : MOVE; gravity, lock and reset counters cleared.
- MOVE:
  - period = max(DROP_MIN, DROP_BASE - level*DROP_STEP), computed with no underflow.
  - Not grounded: gravity counter increments on tick_en; at period-1 with tick_en, drop_tick=1 for one cycle and the counter wraps to 0. The lock counter is held at 0.
  - Grounded: no drop_tick, gravity counter holds, lock counter increments on tick_en.
  - moved with reset count < MAX_RESETS: lock counter -> 0, reset count +1. Otherwise moved has no effect on lock.
  - Lock counter reaches LOCK_TICKS -> LAND.
  - hard_drop -> LAND next cycle, wins over all same-cycle events, no drop_tick.
  - moved and lock expiry in the same cycle: reset wins if resets remain.
  - pause -> PAUSE; wins over gravity and lock, but not over hard_drop.
- PAUSE: all counters frozen, no pulses; pause low -> MOVE with counters intact. pause is ignored outside MOVE.
- LAND (1 cycle): lock_piece=1 -> CLEAR.
- CLEAR: clear_req=1 until clear_done, dropping the same edge. On clear_done:
  - lines += clear_count, saturating at all-ones.
  - Level sub-counter += clear_count; if >= LINES_PER_LEVEL, subtract LINES_PER_LEVEL and level+1, saturating at MAX_LEVEL.
  - Next state -> GEN.
- GAMEOVER: outputs idle, level/lines held for display; exits only on restart.
- done inputs outside the matching req state are ignored.

Decomposition:
- Shared package: state encodings, width constants, and the 3-bit clear_count range.
- One sub-module: tetris_gravity_timer. It takes level, tick_en, grounded, moved and a freeze input, and produces drop_tick and lock_expired. It owns the period computation and the gravity, lock and reset counters.
- The FSM, handshakes and score/level logic stay in the top.

Test Plan:
1. Reset then idle -> NEWBOARD, GEN next cycle, gen_req=1; gen_done with spawn_blocked=0 -> MOVE, gen_req=0 same edge.
2. MOVE, level 0, tick_en every cycle, grounded=0 -> drop_tick every 48th cycle; at level 15 (48-60 < 2) -> every 2nd cycle.
3. Grounded with a moved pulse each 10 ticks -> resets 15 times, then locks 15 ticks after the last reset; lock_piece pulses once, clear_req rises.
4. Four CLEAR passes with clear_count=4,4,1,3 from reset (LINES_PER_LEVEL=10) -> lines=12, level=1, sub-counter 2; lines saturates at 65535.
5. pause in MOVE mid-period (counter=20) for 100 ticks -> no drop_tick; release -> first drop_tick after 28 more ticks. pause asserted in CLEAR -> no effect.
6. hard_drop with gravity expiry in the same cycle -> LAND, no drop_tick. spawn_blocked with gen_done -> GAMEOVER, held until restart. restart during CLEAR with clear_req high -> NEWBOARD, clear_req 0 next cycle. restart_n mid-MOVE -> immediate NEWBOARD and zeroed counters.

Source files
------------

// File: rtl/tetris_game_ctrl_pkg.sv
// tetris_game_ctrl_pkg: shared state encodings, widths and clear-count helper
package tetris_game_ctrl_pkg;

    localparam int STATE_W   = 3;
    localparam int LEVEL_W   = 4;
    localparam int CNT_W     = 3;
    localparam int CLEAR_MAX = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_GEN      = 3'b000,
        ST_MOVE     = 3'b001,
        ST_LAND     = 3'b010,
        ST_CLEAR    = 3'b011,
        ST_NEWBOARD = 3'b100,
        ST_GAMEOVER = 3'b101,
        ST_PAUSE    = 3'b110
    } state_t;

    // clear_count values above four cannot come from a real clear; cap them
    function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] c);
        return (c > CNT_W'(CLEAR_MAX)) ? CNT_W'(CLEAR_MAX) : c;
    endfunction

endpackage

// File: rtl/tetris_gravity_timer.sv
// tetris_gravity_timer: level-dependent gravity period plus lock delay with bounded resets
module tetris_gravity_timer
    import tetris_game_ctrl_pkg::*;
#(
    parameter int DROP_BASE  = 48,
    parameter int DROP_STEP  = 4,
    parameter int DROP_MIN   = 2,
    parameter int LOCK_TICKS = 15,
    parameter int MAX_RESETS = 15
) (
    input  logic               clka,
    input  logic               restart_n,
    input  logic               clear,
    input  logic               freeze,
    input  logic               tick_en,
    input  logic               grounded,
    input  logic               moved,
    input  logic [LEVEL_W-1:0] level,
    output logic               drop_tick,
    output logic               lock_expired
);

    localparam int GW = $clog2(DROP_BASE + 1);
    localparam int LW = $clog2(LOCK_TICKS + 1);
    localparam int RW = $clog2(MAX_RESETS + 1);

    logic [GW-1:0] grav_cnt;
    logic [LW-1:0] lock_cnt;
    logic [RW-1:0] reset_cnt;
    logic [31:0]   reduction;
    logic [31:0]   period;
    logic          step;
    logic          grav_wrap;
    logic          lock_reset;

    // period = max(DROP_MIN, DROP_BASE - level*DROP_STEP) without ever going negative
    always_comb begin
        reduction    = 32'(level) * 32'(DROP_STEP);
        period       = (reduction + 32'(DROP_MIN) >= 32'(DROP_BASE)) ? 32'(DROP_MIN) : 32'(DROP_BASE) - reduction;
        step         = tick_en && !freeze && !clear;
        grav_wrap    = step && !grounded && (32'(grav_cnt) + 32'd1 >= period);
        lock_reset   = moved && !freeze && !clear && (32'(reset_cnt) < 32'(MAX_RESETS));
        lock_expired = step && grounded && !lock_reset && (32'(lock_cnt) + 32'd1 >= 32'(LOCK_TICKS));
    end

    // gravity, lock and reset counters; a move reset beats a same-cycle lock expiry
    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            grav_cnt  <= '0;
            lock_cnt  <= '0;
            reset_cnt <= '0;
            drop_tick <= 1'b0;
        end else if (clear) begin
            grav_cnt  <= '0;
            lock_cnt  <= '0;
            reset_cnt <= '0;
            drop_tick <= 1'b0;
        end else begin
            drop_tick <= grav_wrap;
            if (!freeze) begin
                if (!grounded)
                    grav_cnt <= grav_wrap ? '0 : grav_cnt + GW'(tick_en);
                if (lock_reset || !grounded)
                    lock_cnt <= '0;
                else
                    lock_cnt <= lock_cnt + LW'(tick_en && (32'(lock_cnt) < 32'(LOCK_TICKS)));
                if (lock_reset)
                    reset_cnt <= reset_cnt + RW'(1);
            end
        end
    end

endmodule

// File: rtl/tetris_game_ctrl.sv
// tetris_game_ctrl: game sequencing FSM with piece/clear handshakes and line/level tracking
module tetris_game_ctrl
    import tetris_game_ctrl_pkg::*;
#(
    parameter int DROP_BASE       = 48,
    parameter int DROP_STEP       = 4,
    parameter int DROP_MIN        = 2,
    parameter int LOCK_TICKS      = 15,
    parameter int MAX_RESETS      = 15,
    parameter int LINES_PER_LEVEL = 10,
    parameter int MAX_LEVEL       = 15,
    parameter int LINE_W          = 16
) (
    input  logic              clka,
    input  logic              restart_n,
    input  logic              restart,
    input  logic              tick_en,
    input  logic              pause,
    input  logic              gen_done,
    input  logic              spawn_blocked,
    input  logic              grounded,
    input  logic              moved,
    input  logic              hard_drop,
    input  logic              clear_done,
    input  logic [2:0]        clear_count,
    output logic [2:0]        state,
    output logic              gen_req,
    output logic              drop_tick,
    output logic              lock_piece,
    output logic              clear_req,
    output logic [3:0]        level,
    output logic [LINE_W-1:0] lines
);

    localparam int SW = $clog2(LINES_PER_LEVEL + CLEAR_MAX);

    state_t           st;
    logic [SW-1:0]    sub_cnt;
    logic [CNT_W-1:0] cnt;
    logic [LINE_W:0]  line_sum;
    logic [SW-1:0]    sub_sum;
    logic             level_up;
    logic             freeze;
    logic             clr;
    logic             lock_expired;

    assign state = st;

    // score arithmetic and timer control; timers only run in MOVE and survive PAUSE
    always_comb begin
        cnt      = clamp_count(clear_count);
        line_sum = {1'b0, lines} + (LINE_W + 1)'(cnt);
        sub_sum  = sub_cnt + SW'(cnt);
        level_up = sub_sum >= SW'(LINES_PER_LEVEL);
        freeze   = (st != ST_MOVE) || pause || hard_drop || restart;
        clr      = (st != ST_MOVE) && (st != ST_PAUSE);
    end

    tetris_gravity_timer #(
        .DROP_BASE (DROP_BASE),
        .DROP_STEP (DROP_STEP),
        .DROP_MIN  (DROP_MIN),
        .LOCK_TICKS(LOCK_TICKS),
        .MAX_RESETS(MAX_RESETS)
    ) u_timer (
        .clka        (clka),
        .restart_n   (restart_n),
        .clear       (clr),
        .freeze      (freeze),
        .tick_en     (tick_en),
        .grounded    (grounded),
        .moved       (moved),
        .level       (level),
        .drop_tick   (drop_tick),
        .lock_expired(lock_expired)
    );

    // game FSM; request outputs are registered and change on the same edge as the state
    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            st         <= ST_NEWBOARD;
            gen_req    <= 1'b0;
            clear_req  <= 1'b0;
            lock_piece <= 1'b0;
            level      <= '0;
            lines      <= '0;
            sub_cnt    <= '0;
        end else begin
            lock_piece <= 1'b0;
            if (restart) begin
                st        <= ST_NEWBOARD;
                gen_req   <= 1'b0;
                clear_req <= 1'b0;
            end else begin
                case (st)
                    ST_NEWBOARD: begin
                        level   <= '0;
                        lines   <= '0;
                        sub_cnt <= '0;
                        st      <= ST_GEN;
                        gen_req <= 1'b1;
                    end
                    ST_GEN: if (gen_done) begin
                        gen_req <= 1'b0;
                        st      <= spawn_blocked ? ST_GAMEOVER : ST_MOVE;
                    end
                    ST_MOVE: begin
                        if (hard_drop) begin
                            st         <= ST_LAND;
                            lock_piece <= 1'b1;
                        end else if (pause) begin
                            st <= ST_PAUSE;
                        end else if (lock_expired) begin
                            st         <= ST_LAND;
                            lock_piece <= 1'b1;
                        end
                    end
                    ST_PAUSE: if (!pause) st <= ST_MOVE;
                    ST_LAND: begin
                        st        <= ST_CLEAR;
                        clear_req <= 1'b1;
                    end
                    ST_CLEAR: if (clear_done) begin
                        clear_req <= 1'b0;
                        lines     <= line_sum[LINE_W] ? '1 : line_sum[LINE_W-1:0];
                        sub_cnt   <= level_up ? sub_sum - SW'(LINES_PER_LEVEL) : sub_sum;
                        level     <= (level_up && level < 4'(MAX_LEVEL)) ? level + 4'd1 : level;
                        st        <= ST_GEN;
                        gen_req   <= 1'b1;
                    end
                    ST_GAMEOVER: st <= ST_GAMEOVER;
                    default: begin
                        st        <= ST_NEWBOARD;
                        gen_req   <= 1'b0;
                        clear_req <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tetris_game_ctrl.sv
// tb_tetris_game_ctrl: directed stimulus with a queued scoreboard checked by an independent monitor
module tb_tetris_game_ctrl;
    import tetris_game_ctrl_pkg::*;

    localparam int K_DROP  = 0;
    localparam int K_STATE = 1;
    localparam int K_SNAP  = 2;

    typedef struct {
        int          kind;
        logic [63:0] val;
    } exp_t;

    logic        clka, restart_n, restart, tick_en, pause, gen_done, spawn_blocked;
    logic        grounded, moved, hard_drop, clear_done;
    logic [2:0]  clear_count;
    logic [2:0]  state, state_s;
    logic        gen_req, drop_tick, lock_piece, clear_req;
    logic        gen_req_s, drop_tick_s, lock_piece_s, clear_req_s;
    logic [3:0]  level, level_s;
    logic [15:0] lines;
    logic [7:0]  lines_s;

    exp_t q[$];
    int   checks, errors, tick_no;
    int   m_lv, m_ln, m_sub;
    logic mon_en, snap_req;
    logic [2:0] prev;

    tetris_game_ctrl u_dut (
        .clka(clka), .restart_n(restart_n), .restart(restart), .tick_en(tick_en),
        .pause(pause), .gen_done(gen_done), .spawn_blocked(spawn_blocked),
        .grounded(grounded), .moved(moved), .hard_drop(hard_drop),
        .clear_done(clear_done), .clear_count(clear_count), .state(state),
        .gen_req(gen_req), .drop_tick(drop_tick), .lock_piece(lock_piece),
        .clear_req(clear_req), .level(level), .lines(lines)
    );

    tetris_game_ctrl #(.LINE_W(8)) u_sat (
        .clka(clka), .restart_n(restart_n), .restart(restart), .tick_en(tick_en),
        .pause(pause), .gen_done(gen_done), .spawn_blocked(spawn_blocked),
        .grounded(grounded), .moved(moved), .hard_drop(hard_drop),
        .clear_done(clear_done), .clear_count(clear_count), .state(state_s),
        .gen_req(gen_req_s), .drop_tick(drop_tick_s), .lock_piece(lock_piece_s),
        .clear_req(clear_req_s), .level(level_s), .lines(lines_s)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    function automatic string kname(input int k);
        return (k == K_DROP) ? "drop" : (k == K_STATE) ? "state" : "snap";
    endfunction

    function automatic logic [63:0] pk(input int k, input int t, input logic [2:0] s,
                                       input logic g, input logic c, input logic lp,
                                       input int lv, input int ln);
        logic [15:0] t16, ln16;
        logic [7:0]  sat8;
        logic [3:0]  lv4;
        t16  = 16'(t);
        ln16 = 16'(ln);
        sat8 = (ln > 255) ? 8'd255 : 8'(ln);
        lv4  = 4'(lv);
        return {3'b0, s, g, c, lp, (k == K_DROP), lv4, t16, sat8, s, g, c, lp, lv4, ln16};
    endfunction

    function automatic logic [63:0] obs();
        logic [15:0] t16;
        t16 = 16'(tick_no);
        return {3'b0, state_s, gen_req_s, clear_req_s, lock_piece_s, drop_tick_s, level_s,
                t16, lines_s, state, gen_req, clear_req, lock_piece, level, lines};
    endfunction

    task automatic push(input int k, input int t, input logic [2:0] s, input logic g,
                        input logic c, input logic lp, input int lv, input int ln);
        exp_t e;
        e.kind = k;
        e.val  = pk(k, t, s, g, c, lp, lv, ln);
        q.push_back(e);
    endtask

    task automatic ps(input logic [2:0] s, input logic g, input logic c, input logic lp);
        push(K_STATE, tick_no, s, g, c, lp, m_lv, m_ln);
    endtask

    task automatic pd(input int t);
        push(K_DROP, t, ST_MOVE, 1'b0, 1'b0, 1'b0, m_lv, m_ln);
    endtask

    task automatic snapx(input logic [2:0] s, input logic g, input logic c, input logic lp,
                         input int lv, input int ln);
        push(K_SNAP, tick_no, s, g, c, lp, lv, ln);
        snap_req = 1'b1;
    endtask

    task automatic cmp(input int k, input logic [63:0] v);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL %s check: unexpected observation %h at tick %0d, nothing expected", kname(k), v, tick_no);
        end else begin
            e = q.pop_front();
            if (e.kind != k || e.val !== v) begin
                errors++;
                $display("FAIL %s check: got %h, expected %s %h", kname(k), v, kname(e.kind), e.val);
            end
        end
    endtask

    // monitor: samples 1 time unit after each rising edge, independent of stimulus
    initial begin
        prev = 3'b0;
        forever begin
            @(posedge clka);
            #1;
            if (mon_en) begin
                if (drop_tick) cmp(K_DROP, obs());
                if (state != prev) cmp(K_STATE, obs());
                if (snap_req) begin
                    cmp(K_SNAP, obs());
                    snap_req = 1'b0;
                end
            end
            prev = state;
        end
    end

    task automatic nxt();
        @(negedge clka);
        tick_en    = 1'b0;
        gen_done   = 1'b0;
        clear_done = 1'b0;
        moved      = 1'b0;
        hard_drop  = 1'b0;
        restart    = 1'b0;
    endtask

    task automatic tk();
        nxt();
        tick_en = 1'b1;
        tick_no++;
    endtask

    task automatic do_clear(input int c);
        nxt();
        clear_done  = 1'b1;
        clear_count = 3'(c);
        m_ln  = (m_ln + c > 65535) ? 65535 : m_ln + c;
        m_sub = m_sub + c;
        if (m_sub >= 10) begin
            m_sub = m_sub - 10;
            if (m_lv < 15) m_lv++;
        end
        ps(ST_GEN, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic piece(input int c);
        nxt();
        gen_done = 1'b1;
        ps(ST_MOVE, 1'b0, 1'b0, 1'b0);
        nxt();
        hard_drop = 1'b1;
        ps(ST_LAND, 1'b0, 1'b0, 1'b1);
        nxt();
        ps(ST_CLEAR, 1'b0, 1'b1, 1'b0);
        do_clear(c);
    endtask

    initial begin
        checks = 0; errors = 0; tick_no = 0;
        m_lv = 0; m_ln = 0; m_sub = 0;
        mon_en = 1'b0; snap_req = 1'b0;
        restart_n = 1'b0; restart = 1'b0; tick_en = 1'b0; pause = 1'b0;
        gen_done = 1'b0; spawn_blocked = 1'b0; grounded = 1'b0; moved = 1'b0;
        hard_drop = 1'b0; clear_done = 1'b0; clear_count = 3'd0;
        repeat (2) nxt();
        nxt();
        mon_en = 1'b1;
        snapx(ST_NEWBOARD, 1'b0, 1'b0, 1'b0, 0, 0);
        nxt();
        restart_n = 1'b1;
        ps(ST_GEN, 1'b1, 1'b0, 1'b0);
        nxt();
        snapx(ST_GEN, 1'b1, 1'b0, 1'b0, 0, 0);
        nxt();
        gen_done = 1'b1;
        ps(ST_MOVE, 1'b0, 1'b0, 1'b0);
        nxt();
        clear_done  = 1'b1;
        clear_count = 3'd4;
        // level-0 gravity: one drop every 48 ticks
        tick_no = 0;
        pd(48);
        pd(96);
        repeat (96) tk();
        nxt();
        // pause at gravity count 20 for 100 ticks, then 28 more to the next drop
        tick_no = 0;
        repeat (20) tk();
        tk();
        pause = 1'b1;
        ps(ST_PAUSE, 1'b0, 1'b0, 1'b0);
        repeat (99) tk();
        nxt();
        pause = 1'b0;
        ps(ST_MOVE, 1'b0, 1'b0, 1'b0);
        pd(148);
        repeat (28) tk();
        nxt();
        // grounded lock delay: 15 resets, 16th move ignored, lock 15 ticks after last reset
        tick_no  = 0;
        grounded = 1'b1;
        for (int k = 1; k <= 165; k++) begin
            tk();
            if (k % 10 == 0 && k <= 160) moved = 1'b1;
            if (k == 165) ps(ST_LAND, 1'b0, 1'b0, 1'b1);
        end
        nxt();
        grounded = 1'b0;
        ps(ST_CLEAR, 1'b0, 1'b1, 1'b0);
        // pause and gen_done are ignored while clearing
        nxt();
        pause    = 1'b1;
        gen_done = 1'b1;
        nxt();
        nxt();
        snapx(ST_CLEAR, 1'b0, 1'b1, 1'b0, 0, 0);
        nxt();
        pause = 1'b0;
        // clear passes 4,4,1,3 -> 12 lines, level 1
        do_clear(4);
        piece(4);
        piece(1);
        piece(3);
        nxt();
        snapx(ST_GEN, 1'b1, 1'b0, 1'b0, 1, 12);
        repeat (70) piece(4);
        nxt();
        snapx(ST_GEN, 1'b1, 1'b0, 1'b0, 15, 292);
        // level-15 gravity uses the 2-tick floor; hard drop suppresses a coincident drop
        nxt();
        gen_done = 1'b1;
        tick_no  = 0;
        ps(ST_MOVE, 1'b0, 1'b0, 1'b0);
        pd(2);
        pd(4);
        pd(6);
        repeat (7) tk();
        tk();
        hard_drop = 1'b1;
        ps(ST_LAND, 1'b0, 1'b0, 1'b1);
        nxt();
        ps(ST_CLEAR, 1'b0, 1'b1, 1'b0);
        // restart while clear_req is high
        nxt();
        restart = 1'b1;
        ps(ST_NEWBOARD, 1'b0, 1'b0, 1'b0);
        m_lv = 0; m_ln = 0; m_sub = 0;
        nxt();
        ps(ST_GEN, 1'b1, 1'b0, 1'b0);
        // blocked spawn -> GAMEOVER, deaf to everything but restart
        nxt();
        gen_done      = 1'b1;
        spawn_blocked = 1'b1;
        ps(ST_GAMEOVER, 1'b0, 1'b0, 1'b0);
        nxt();
        spawn_blocked = 1'b0;
        gen_done      = 1'b1;
        clear_done    = 1'b1;
        hard_drop     = 1'b1;
        pause         = 1'b1;
        repeat (2) nxt();
        pause = 1'b0;
        snapx(ST_GAMEOVER, 1'b0, 1'b0, 1'b0, 0, 0);
        nxt();
        restart = 1'b1;
        ps(ST_NEWBOARD, 1'b0, 1'b0, 1'b0);
        nxt();
        ps(ST_GEN, 1'b1, 1'b0, 1'b0);
        // asynchronous reset mid-MOVE clears the gravity counter
        nxt();
        gen_done = 1'b1;
        tick_no  = 0;
        ps(ST_MOVE, 1'b0, 1'b0, 1'b0);
        repeat (20) tk();
        nxt();
        restart_n = 1'b0;
        ps(ST_NEWBOARD, 1'b0, 1'b0, 1'b0);
        nxt();
        restart_n = 1'b1;
        ps(ST_GEN, 1'b1, 1'b0, 1'b0);
        nxt();
        gen_done = 1'b1;
        tick_no  = 0;
        ps(ST_MOVE, 1'b0, 1'b0, 1'b0);
        pd(48);
        repeat (48) tk();
        repeat (4) nxt();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain check: %0d expected events never observed, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
